cntr_seg_display: RTL and testbench

Downstream display stage for the 4-bit synchronous up counter. It captures the counter's binary value and converts it to two BCD digits (00–15). It then time-multiplexes those digits onto a two-digit common-anode seven-segment display. A one-cycle blanking gap between digits suppresses ghosting.

---
 rtl/cntr_seg_pkg.sv | 30 +++
 rtl/cntr_seg_display_seg7_decode.sv | 29 ++
 rtl/cntr_seg_display.sv | 173 +++++++++++++++++
 tb/tb_cntr_seg_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cntr_seg_pkg.sv
// Shared definitions for the two-digit counter display.
// Contents: scan-state enum, blank/segment-code constants for the
// active-low {g,f,e,d,c,b,a} encoding, and anode enable patterns.
package cntr_seg_pkg;

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        GAP_T    = 2'd1,
        DIG_TENS = 2'd2,
        GAP_O    = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Active-low anode patterns.
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/cntr_seg_display_seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment code.
// Ports:
//   digit_i  [3:0]  digit value; 10..15 are not digits and produce a blank
//   seg_o    [6:0]  {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import cntr_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cntr_seg_display.sv
// cntr_seg_display: captures a 4-bit counter value, splits it into two BCD
// digits (00..15) and time-multiplexes them onto a two-digit common-anode
// seven-segment display, with a one-cycle blank gap between digits.
//
// Parameters:
//   REFRESH_DIV  cycles each digit is lit (>= 2)
//   CNT_W        captured value width (only 4 is meaningful)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cnt_in       binary count from the upstream counter
//   cnt_valid    capture strobe, cnt_in latched on a clk edge while high
//   seg          segment drive {g,f,e,d,c,b,a}, active-low, registered
//   an           anode enables, active-low, an[0]=ones an[1]=tens, registered
//   dp           decimal point, active-low, registered
//   dbg_state_o  current scan state (debug visibility only)
//
// Optional build macro WRAP_DETECT_EN: adds a sticky flag, set when a
// capture loads 0 while the held value is 15; while set, dp is lit during
// the ones digit. Without the macro dp is constantly 1.
//
// Timing: outputs are registered from the current state and held value, so
// a capture at edge N is visible from edge N+1, and the first edge after
// reset release already presents the ones digit.
module cntr_seg_display
    import cntr_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             cnt_valid,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             dp,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RCNT_LAST = CW'(REFRESH_DIV - 1);

    scan_state_e      state_q, state_d;
    logic [CW-1:0]    rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cap_val_q, cap_val_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             dp_q, dp_d;

    // BCD split of the held value.
    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       digit_sel;
    logic [6:0]       digit_code;

    assign tens = (cap_val_q >= CNT_W'(10));
    assign ones = tens ? 4'(cap_val_q - CNT_W'(10)) : 4'(cap_val_q);

    // One shared decoder; the mux feeds whichever digit is being scanned.
    assign digit_sel = (state_q == DIG_TENS) ? {3'b000, tens} : ones;

    seg7_decode u_dec (
        .digit_i (digit_sel),
        .seg_o   (digit_code)
    );

    assign cap_val_d = cnt_valid ? cnt_in : cap_val_q;

`ifdef WRAP_DETECT_EN
    logic wrap_q, wrap_d;

    assign wrap_d = wrap_q
                  | (cnt_valid && (cnt_in == '0) && (cap_val_q == CNT_W'(15)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
`endif

    // State register, refresh count, capture and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIG_ONES;
            rcnt_q    <= '0;
            cap_val_q <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            cap_val_q <= cap_val_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    // Next-state logic. The refresh count only advances in DIG states and
    // is zero on entry to each DIG state.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            DIG_ONES: begin
                if (rcnt_q == RCNT_LAST) begin
                    state_d = GAP_T;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q + CW'(1);
                end
            end
            GAP_T: begin
                state_d = DIG_TENS;
                rcnt_d  = '0;
            end
            DIG_TENS: begin
                if (rcnt_q == RCNT_LAST) begin
                    state_d = GAP_O;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q + CW'(1);
                end
            end
            GAP_O: begin
                state_d = DIG_ONES;
                rcnt_d  = '0;
            end
            default: begin
                state_d = DIG_ONES;
                rcnt_d  = '0;
            end
        endcase
    end

    // Output logic: value presented on the registered outputs next edge.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        dp_d  = 1'b1;
        case (state_q)
            DIG_ONES: begin
                seg_d = digit_code;
                an_d  = AN_ONES;
            end
            DIG_TENS: begin
                // Leading zero is suppressed by leaving the digit dark.
                if (tens) begin
                    seg_d = digit_code;
                    an_d  = AN_TENS;
                end
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = AN_OFF;
            end
        endcase
`ifdef WRAP_DETECT_EN
        dp_d = !(wrap_q && (state_q == DIG_ONES));
`endif
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cntr_seg_display.sv
// Bench for cntr_seg_display with REFRESH_DIV=4. The driver issues one
// input vector per cycle on the falling edge and pushes the display output
// expected after the next rising edge; the monitor pops and compares.
// The reference model works from frame position and decimal arithmetic.
module tb_cntr_seg_display;

    localparam int R = 4;
    localparam int F = 2 * (R + 1);

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic [1:0] dbg_state;

    cntr_seg_display #(.REFRESH_DIV(R), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .cnt_valid   (cnt_valid),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int  k_edges;   // rising edges since reset release
    int  held_val;  // value captured so far
    bit  wrapped;

    logic [9:0] exp_q[$];   // {seg, an, dp}
    int checks;
    int errors;

    // Expected {seg,an,dp} after edge k, given the value held before it.
    function automatic logic [9:0] model_out(int k, int v, bit w);
        int p;
        logic [6:0] s;
        logic [1:0] a;
        logic       d;
        p = (k - 1) % F;
        s = 7'h7F;
        a = 2'b11;
        d = 1'b1;
        if (p < R) begin
            s = seg_tab[v % 10];
            a = 2'b10;
`ifdef WRAP_DETECT_EN
            d = w ? 1'b0 : 1'b1;
`endif
        end else if (p > R && p < F - 1) begin
            if (v >= 10) begin
                s = seg_tab[v / 10];
                a = 2'b01;
            end
        end
        if (w) d = d;
        return {s, a, d};
    endfunction

    // Driver: one cycle of stimulus plus its expected response.
    task automatic drive_cycle(input bit rst_n_v, input bit valid, input int val);
        @(negedge clk);
        rst       = rst_n_v;
        cnt_valid = valid;
        cnt_in    = 4'(val);
        if (!rst_n_v) begin
            k_edges  = 0;
            held_val = 0;
            wrapped  = 1'b0;
            exp_q.push_back({7'h7F, 2'b11, 1'b1});
        end else begin
            k_edges++;
            exp_q.push_back(model_out(k_edges, held_val, wrapped));
            if (valid) begin
                if (val == 0 && held_val == 15) wrapped = 1'b1;
                held_val = val;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 0);
    endtask

    task automatic capture(input int val);
        drive_cycle(1'b1, 1'b1, val);
    endtask

    // Reset asserted between edges must blank outputs without waiting.
    task automatic reset_mid_scan();
        @(negedge clk);
        rst       = 1'b0;
        cnt_valid = 1'b0;
        #1;
        checks++;
        if ({seg, an, dp} !== {7'h7F, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got seg=%h an=%b dp=%b, want seg=7f an=11 dp=1",
                     seg, an, dp);
        end
        k_edges  = 0;
        held_val = 0;
        wrapped  = 1'b0;
        exp_q.push_back({7'h7F, 2'b11, 1'b1});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({seg, an, dp} !== e) begin
                    errors++;
                    $display("FAIL display t=%0t: got seg=%h an=%b dp=%b, want seg=%h an=%b dp=%b",
                             $time, seg, an, dp, e[9:3], e[2:1], e[0]);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        k_edges   = 0;
        held_val  = 0;
        wrapped   = 1'b0;
        rst       = 1'b0;
        cnt_valid = 1'b0;
        cnt_in    = 4'd0;

        // Held in reset, then release with no captures: two full frames.
        drive_cycle(1'b0, 1'b0, 0);
        drive_cycle(1'b0, 1'b0, 0);
        idle_cycles(2 * F);

        // Single-digit value: tens blanked.
        capture(7);
        idle_cycles(F + 1);

        // Two-digit values.
        capture(13);
        idle_cycles(F + 1);
        capture(15);
        idle_cycles(F);
        capture(9);
        idle_cycles(F);
        capture(0);
        idle_cycles(F);

        // Capture mid-way through the ones digit (edges land at count 2).
        while ((k_edges % F) != 1) idle_cycles(1);
        capture(12);
        idle_cycles(F);

        // Capture landing in a gap.
        while ((k_edges % F) != R - 1) idle_cycles(1);
        capture(11);
        idle_cycles(F);

        // Wrap 15 -> 0.
        capture(15);
        idle_cycles(3);
        capture(0);
        idle_cycles(2 * F);

        // Continuous tracking.
        for (int i = 0; i < 3 * F; i++) capture($urandom_range(0, 15));

        // Randomised traffic, biased towards the wrap boundary.
        for (int i = 0; i < 400; i++) begin
            int v;
            v = (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 0)
                                             : $urandom_range(0, 15));
            drive_cycle(1'b1, ($urandom_range(0, 2) == 0), v);
        end

        // Reset in the middle of a lit tens digit.
        capture(13);
        while ((k_edges % F) != R + 2) idle_cycles(1);
        reset_mid_scan();
        drive_cycle(1'b0, 1'b0, 0);
        idle_cycles(F + 2);
        capture(4);
        idle_cycles(F);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
